// File: rtl/rx_video_pkg.sv
// rx_video_pkg: shared types and widths for the AXI4-Stream video receive checker
package rx_video_pkg;
    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;
    localparam int CNT_W = 16;
    localparam int PIX_CNT_W = 12;
    localparam logic [CNT_W-1:0] SAT_MAX = 16'hFFFF;
endpackage

// File: rtl/axis_video_rx_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    // count up on inc, hold once every bit is set
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != {WIDTH{1'b1}})
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/axis_video_rx_checker.sv
// axis_video_rx_checker: AXI4-Stream video sink checking SOF/EOL framing and summing each frame
module axis_video_rx_checker
    import rx_video_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int PIX_PER_LINE = 640,
    parameter int LINES        = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic [DATA_W-1:0] s_axis_video_tdata,
    input  logic              s_axis_video_tvalid,
    output logic              s_axis_video_tready,
    input  logic              s_axis_video_tuser,
    input  logic              s_axis_video_tlast,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [31:0]       frame_sum,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam logic [PIX_CNT_W:0]   PIX_N    = (PIX_CNT_W+1)'(PIX_PER_LINE);
    localparam logic [PIX_CNT_W:0]   PIX_LATE = (PIX_CNT_W+1)'(PIX_PER_LINE + 1);
    localparam logic [PIX_CNT_W-1:0] LN_LAST  = PIX_CNT_W'(LINES - 1);

    state_t                 state_q, state_d;
    logic                   en_q;
    logic                   beat;
    logic [31:0]            pix;
    logic [PIX_CNT_W:0]     n;
    logic [PIX_CNT_W-1:0]   px_q, px_d, ln_q, ln_d;
    logic [31:0]            sum_q, sum_d;
    logic                   err_f_q, err_f_d, line_err_q, line_err_d;
    logic                   late, early, err_inc, drop_inc, done_d;

    assign beat = s_axis_video_tvalid & s_axis_video_tready;
    assign pix  = 32'(s_axis_video_tdata);
    assign n    = {1'b0, px_q} + 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= WAIT_SOF;
        else
            state_q <= state_d;
    end

    // next state: any SOF (re)starts a frame, the last EOL of the last line ends it
    always_comb begin
        state_d = state_q;
        if (beat && s_axis_video_tuser)
            state_d = (s_axis_video_tlast && LINES == 1) ? WAIT_SOF : ACTIVE;
        else if (beat && state_q == ACTIVE && s_axis_video_tlast && ln_q == LN_LAST)
            state_d = WAIT_SOF;
    end

    // FSM outputs: ready only when enabled, not throttled and not in reset
    always_comb begin
        s_axis_video_tready = en_q & ~stall & ~rst;
    end

    // per-beat structure checks and checksum update
    always_comb begin
        sum_d      = sum_q;
        px_d       = px_q;
        ln_d       = ln_q;
        err_f_d    = err_f_q;
        line_err_d = line_err_q;
        late       = 1'b0;
        early      = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;
        done_d     = 1'b0;
        if (beat && s_axis_video_tuser) begin
            err_inc    = (state_q == ACTIVE) | s_axis_video_tlast;
            sum_d      = pix;
            px_d       = s_axis_video_tlast ? '0 : PIX_CNT_W'(1);
            ln_d       = s_axis_video_tlast ? PIX_CNT_W'(1) : '0;
            err_f_d    = s_axis_video_tlast;
            line_err_d = 1'b0;
            done_d     = s_axis_video_tlast && LINES == 1;
        end else if (beat && state_q == WAIT_SOF) begin
            drop_inc = 1'b1;
        end else if (beat) begin
            sum_d      = sum_q + pix;
            late       = !s_axis_video_tlast && n == PIX_LATE && !line_err_q;
            early      = s_axis_video_tlast && n != PIX_N && !line_err_q;
            err_inc    = late | early;
            err_f_d    = err_f_q | late | early;
            line_err_d = s_axis_video_tlast ? 1'b0 : (line_err_q | late);
            px_d       = s_axis_video_tlast ? '0 : (n[PIX_CNT_W] ? '1 : n[PIX_CNT_W-1:0]);
            ln_d       = s_axis_video_tlast ? ln_q + 1'b1 : ln_q;
            done_d     = s_axis_video_tlast && ln_q == LN_LAST;
        end
    end

    // datapath registers; a frame result is published the cycle after its last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            px_q       <= '0;
            ln_q       <= '0;
            sum_q      <= '0;
            err_f_q    <= 1'b0;
            line_err_q <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_sum  <= '0;
            frame_cnt  <= '0;
        end else begin
            en_q       <= en;
            px_q       <= px_d;
            ln_q       <= ln_d;
            sum_q      <= sum_d;
            err_f_q    <= err_f_d;
            line_err_q <= line_err_d;
            frame_done <= done_d;
            if (done_d) begin
                frame_ok  <= ~err_f_d;
                frame_sum <= sum_d;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );
endmodule

// File: tb/tb_axis_video_rx_checker.sv
// tb_axis_video_rx_checker: scenario table plus frame scoreboard for the video receive checker
module tb_axis_video_rx_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        frame_done, frame_ok;
    logic [31:0] frame_sum;
    logic [15:0] frame_cnt, err_cnt, drop_cnt;

    axis_video_rx_checker #(.DATA_W(32), .PIX_PER_LINE(4), .LINES(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .stall               (stall),
        .s_axis_video_tdata  (tdata),
        .s_axis_video_tvalid (tvalid),
        .s_axis_video_tready (tready),
        .s_axis_video_tuser  (tuser),
        .s_axis_video_tlast  (tlast),
        .frame_done          (frame_done),
        .frame_ok            (frame_ok),
        .frame_sum           (frame_sum),
        .frame_cnt           (frame_cnt),
        .err_cnt             (err_cnt),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          u;
        bit          l;
        bit          fin;
    } beat_t;

    typedef struct {
        int          kind;
        bit          stall_mode;
        int          exp_err;
        int          exp_drop;
        bit          exp_ok;
        logic [31:0] exp_sum;
        int          exp_cnt;
    } scn_t;

    typedef struct {
        bit          ok;
        logic [31:0] sum;
        int          cyc;
    } exp_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    stall_mode = 1'b0;
    bit    cur_ok;
    logic [31:0] cur_sum;
    beat_t beats[$];
    exp_t  sb[$];
    scn_t  scn[6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // every frame_done pulse must match the next expected frame, one cycle after its last beat
    always @(negedge clk) begin
        if (frame_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_ok", {31'd0, frame_ok}, {31'd0, e.ok});
                chk("done_sum", frame_sum, e.sum);
                chk("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic add(input logic [31:0] d, input bit u, input bit l, input bit fin);
        beat_t b;
        b.d = d; b.u = u; b.l = l; b.fin = fin;
        beats.push_back(b);
    endtask

    task automatic add_clean();
        for (int i = 0; i < 12; i++) add(i, i == 0, i % 4 == 3, i == 11);
    endtask

    task automatic send_beat(input beat_t b);
        bit acc;
        tdata = b.d; tuser = b.u; tlast = b.l; tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            stall = stall_mode ? ~stall : 1'b0;
            if (acc) begin
                if (b.fin) begin
                    exp_t e;
                    e.ok = cur_ok; e.sum = cur_sum; e.cyc = cyc;
                    sb.push_back(e);
                end
                return;
            end
        end
        chk("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_all();
        while (beats.size() > 0) send_beat(beats.pop_front());
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(string tag);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_ok"}, {31'd0, frame_ok}, 32'd0);
        chk({tag, "_sum"}, frame_sum, 32'd0);
        chk({tag, "_cnt"}, {16'd0, frame_cnt}, 32'd0);
        chk({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
        chk({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
        chk({tag, "_tready"}, {31'd0, tready}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("reset");
    endtask

    task automatic check_end(scn_t s);
        chk("err_cnt", {16'd0, err_cnt}, s.exp_err);
        chk("drop_cnt", {16'd0, drop_cnt}, s.exp_drop);
        chk("frame_cnt", {16'd0, frame_cnt}, s.exp_cnt);
        chk("frame_ok", {31'd0, frame_ok}, {31'd0, s.exp_ok});
        chk("frame_sum", frame_sum, s.exp_sum);
        chk("pending_frames", sb.size(), 32'd0);
    endtask

    initial begin
        //        kind stall err drop ok  sum      frames
        scn[0] = '{0, 1'b0, 0, 0, 1'b1, 32'h42, 1};
        scn[1] = '{1, 1'b0, 1, 0, 1'b0, 32'h37, 1};
        scn[2] = '{2, 1'b0, 1, 0, 1'b0, 32'h5B, 1};
        scn[3] = '{3, 1'b0, 1, 0, 1'b1, 32'h42, 1};
        scn[4] = '{4, 1'b1, 0, 3, 1'b1, 32'h42, 1};
        scn[5] = '{5, 1'b0, 0, 0, 1'b1, 32'h42, 2};
        en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            do_reset();
            stall_mode = scn[s].stall_mode;
            cur_ok = scn[s].exp_ok;
            cur_sum = scn[s].exp_sum;
            case (scn[s].kind)
                0: add_clean();
                1: for (int i = 0; i < 11; i++) add(i, i == 0, i == 2 || i == 6 || i == 10, i == 10);
                2: for (int i = 0; i < 14; i++) add(i, i == 0, i == 3 || i == 9 || i == 13, i == 13);
                3: begin
                    for (int i = 0; i < 5; i++) add(i, i == 0, i == 3, 1'b0);
                    add_clean();
                end
                4: begin
                    for (int i = 0; i < 3; i++) add(100 + i, 1'b0, 1'b0, 1'b0);
                    add_clean();
                end
                default: begin
                    add_clean();
                    add_clean();
                end
            endcase
            send_all();
            check_end(scn[s]);
        end
        // reset in the middle of a frame abandons it silently
        do_reset();
        stall_mode = 1'b0;
        for (int i = 0; i < 6; i++) add(i, i == 0, i == 3, 1'b0);
        while (beats.size() > 0) send_beat(beats.pop_front());
        rst = 1'b1;
        tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("midreset");
        cur_ok = 1'b1;
        cur_sum = 32'h42;
        add_clean();
        send_all();
        check_end('{0, 1'b0, 0, 0, 1'b1, 32'h42, 1});
        // enable dropped mid-frame holds state and the frame resumes
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                tvalid = 1'b0;
                en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("en_low_tready", {31'd0, tready}, 32'd0);
                en = 1'b1;
            end
            add(i, i == 0, i % 4 == 3, i == 11);
            send_beat(beats.pop_front());
        end
        send_all();
        check_end('{0, 1'b0, 0, 0, 1'b1, 32'h42, 1});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
